sdram_burst_scheduler: RTL and testbench

- Single-clock scheduler in the SDRAM reference clock domain.
- Decides when a write burst (write-FIFO to SDRAM) or a read burst (SDRAM to read-FIFO) is issued to the SDRAM controller.
- Holds the request/ack handshake and advances and wraps the write/read frame addresses.
- Sits between the two dual-clock FIFOs and the SDRAM command controller; replaces ad-hoc request logic with round-robin arbitration.

---
 rtl/sdram_burst_scheduler_if.sv | 30 +++
 rtl/sdram_burst_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_sdram_burst_scheduler.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_burst_scheduler_if.sv
// SDRAM controller side of the burst scheduler:
// burst requests, their addresses and the controller acks.
interface sdram_burst_scheduler_if #(
    parameter int ADDR_W = 22
);
    logic              sdram_wr_req;
    logic              sdram_rd_req;
    logic [ADDR_W-1:0] sdram_wraddr;
    logic [ADDR_W-1:0] sdram_rdaddr;
    logic              sdram_wr_ack;
    logic              sdram_rd_ack;

    modport master (
        output sdram_wr_req,
        output sdram_rd_req,
        output sdram_wraddr,
        output sdram_rdaddr,
        input  sdram_wr_ack,
        input  sdram_rd_ack
    );

    modport slave (
        input  sdram_wr_req,
        input  sdram_rd_req,
        input  sdram_wraddr,
        input  sdram_rdaddr,
        output sdram_wr_ack,
        output sdram_rd_ack
    );
endinterface

// File: rtl/sdram_burst_scheduler.sv
// Round-robin write/read burst scheduler between the frame FIFOs
// and the SDRAM command controller, with frame address wrapping.
module sdram_burst_scheduler #(
    parameter int ADDR_W      = 22,
    parameter int LEN_W       = 9,
    parameter int USEDW_W     = 10,
    parameter int RDF_DEPTH   = 1024,
    parameter int ACK_TIMEOUT = 4095
) (
    input  logic                    clk_ref,
    input  logic                    rst,
    input  logic                    sdram_init_done,
    input  logic [USEDW_W-1:0]      wrf_usedw,
    input  logic [USEDW_W-1:0]      rdf_usedw,
    input  logic                    data_valid,
    input  logic [LEN_W-1:0]        wr_length,
    input  logic [LEN_W-1:0]        rd_length,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [ADDR_W-1:0]       wr_max_addr,
    input  logic                    wr_load,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic [ADDR_W-1:0]       rd_max_addr,
    input  logic                    rd_load,
    sdram_burst_scheduler_if.master sdram,
    output logic                    frame_write_done,
    output logic                    frame_read_done,
    output logic                    ack_timeout_err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_ACT  = 3'd2;
    localparam logic [2:0] DONE_WR = 3'd3;
    localparam logic [2:0] RD_REQ  = 3'd4;
    localparam logic [2:0] RD_ACT  = 3'd5;
    localparam logic [2:0] DONE_RD = 3'd6;

    localparam int NW  = USEDW_W + 2;
    localparam int AW1 = ADDR_W + 1;
    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    logic [2:0]        state;
    logic [TO_W-1:0]   to_cnt;
    logic              last_rd;
    logic              wr_req;
    logic              rd_req;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_ld_pend;
    logic              rd_ld_pend;

    logic              wr_need;
    logic              rd_need;
    logic [NW-1:0]     rd_fill;
    logic              grant_wr;
    logic              grant_rd;
    logic [AW1-1:0]    wr_next;
    logic [AW1-1:0]    rd_next;
    logic              wr_wrap;
    logic              rd_wrap;
    logic              wr_ld_now;
    logic              rd_ld_now;
    logic              wr_busy;
    logic              rd_busy;

    assign wr_need = NW'(wrf_usedw) >= NW'(wr_length);
    assign rd_fill = NW'(rdf_usedw) + NW'(rd_length);
    assign rd_need = data_valid && (rd_fill <= NW'(RDF_DEPTH));

    // On a tie the direction not served last wins.
    assign grant_wr = wr_need && (!rd_need || last_rd);
    assign grant_rd = rd_need && !grant_wr;

    assign wr_next = {1'b0, wr_ptr} + AW1'(wr_length);
    assign rd_next = {1'b0, rd_ptr} + AW1'(rd_length);
    assign wr_wrap = wr_next >= {1'b0, wr_max_addr};
    assign rd_wrap = rd_next >= {1'b0, rd_max_addr};

    assign wr_ld_now = wr_load | wr_ld_pend;
    assign rd_ld_now = rd_load | rd_ld_pend;

    assign wr_busy = (state == WR_REQ) || (state == WR_ACT)
                  || (state == DONE_WR);
    assign rd_busy = (state == RD_REQ) || (state == RD_ACT)
                  || (state == DONE_RD);

    assign frame_write_done = (state == DONE_WR) && !wr_ld_now && wr_wrap;
    assign frame_read_done  = (state == DONE_RD) && !rd_ld_now && rd_wrap;

    assign sdram.sdram_wr_req = wr_req;
    assign sdram.sdram_rd_req = rd_req;
    assign sdram.sdram_wraddr = wr_ptr;
    assign sdram.sdram_rdaddr = rd_ptr;

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state           <= IDLE;
            to_cnt          <= '0;
            last_rd         <= 1'b1;
            wr_req          <= 1'b0;
            rd_req          <= 1'b0;
            ack_timeout_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (sdram_init_done && grant_wr) begin
                        state  <= WR_REQ;
                        wr_req <= 1'b1;
                    end else if (sdram_init_done && grant_rd) begin
                        state  <= RD_REQ;
                        rd_req <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (sdram.sdram_wr_ack) begin
                        state  <= WR_ACT;
                        wr_req <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        state           <= IDLE;
                        wr_req          <= 1'b0;
                        ack_timeout_err <= 1'b1;
                        last_rd         <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WR_ACT: begin
                    if (!sdram.sdram_wr_ack) state <= DONE_WR;
                end
                DONE_WR: begin
                    state   <= IDLE;
                    last_rd <= 1'b0;
                end
                RD_REQ: begin
                    if (sdram.sdram_rd_ack) begin
                        state  <= RD_ACT;
                        rd_req <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        state           <= IDLE;
                        rd_req          <= 1'b0;
                        ack_timeout_err <= 1'b1;
                        last_rd         <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RD_ACT: begin
                    if (!sdram.sdram_rd_ack) state <= DONE_RD;
                end
                DONE_RD: begin
                    state   <= IDLE;
                    last_rd <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    wr_req <= 1'b0;
                    rd_req <= 1'b0;
                end
            endcase
        end
    end

    // A load arriving mid-burst is held back so the address stays put.
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            wr_ptr     <= '0;
            wr_ld_pend <= 1'b0;
        end else if (state == DONE_WR) begin
            wr_ld_pend <= 1'b0;
            if (wr_ld_now || wr_wrap) wr_ptr <= wr_addr;
            else                      wr_ptr <= wr_next[ADDR_W-1:0];
        end else if (wr_busy) begin
            if (wr_load) wr_ld_pend <= 1'b1;
        end else if (wr_ld_now) begin
            wr_ptr     <= wr_addr;
            wr_ld_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            rd_ptr     <= '0;
            rd_ld_pend <= 1'b0;
        end else if (state == DONE_RD) begin
            rd_ld_pend <= 1'b0;
            if (rd_ld_now || rd_wrap) rd_ptr <= rd_addr;
            else                      rd_ptr <= rd_next[ADDR_W-1:0];
        end else if (rd_busy) begin
            if (rd_load) rd_ld_pend <= 1'b1;
        end else if (rd_ld_now) begin
            rd_ptr     <= rd_addr;
            rd_ld_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Bench for sdram_burst_scheduler: directed handshake, wrap, load and
// timeout steps, then random bursts against a frame-pointer model.
module tb_sdram_burst_scheduler;

    localparam int ADDR_W = 22;
    localparam int ACK_TO = 4095;

    logic              clk_ref;
    logic              rst;
    logic              sdram_init_done;
    logic [9:0]        wrf_usedw;
    logic [9:0]        rdf_usedw;
    logic              data_valid;
    logic [8:0]        wr_length;
    logic [8:0]        rd_length;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wr_max_addr;
    logic              wr_load;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_max_addr;
    logic              rd_load;
    logic              frame_write_done;
    logic              frame_read_done;
    logic              ack_timeout_err;

    int checks;
    int failures;

    sdram_burst_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    sdram_burst_scheduler #(
        .ADDR_W(ADDR_W), .LEN_W(9), .USEDW_W(10),
        .RDF_DEPTH(1024), .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk_ref(clk_ref),
        .rst(rst),
        .sdram_init_done(sdram_init_done),
        .wrf_usedw(wrf_usedw),
        .rdf_usedw(rdf_usedw),
        .data_valid(data_valid),
        .wr_length(wr_length),
        .rd_length(rd_length),
        .wr_addr(wr_addr),
        .wr_max_addr(wr_max_addr),
        .wr_load(wr_load),
        .rd_addr(rd_addr),
        .rd_max_addr(rd_max_addr),
        .rd_load(rd_load),
        .sdram(bus),
        .frame_write_done(frame_write_done),
        .frame_read_done(frame_read_done),
        .ack_timeout_err(ack_timeout_err)
    );

    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    task automatic tick();
        @(negedge clk_ref);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic req_of(input bit is_wr);
        return is_wr ? bus.sdram_wr_req : bus.sdram_rd_req;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input bit is_wr);
        return is_wr ? bus.sdram_wraddr : bus.sdram_rdaddr;
    endfunction

    function automatic logic pulse_of(input bit is_wr);
        return is_wr ? frame_write_done : frame_read_done;
    endfunction

    // Frame pointer rule: advance by length, fall back to base at the end.
    function automatic logic [ADDR_W-1:0] advance(
        input logic [ADDR_W-1:0] p, input int len,
        input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] max,
        output bit wrap);
        longint n;
        n = longint'(p) + longint'(len);
        wrap = (n >= longint'(max));
        return wrap ? base : ADDR_W'(n);
    endfunction

    task automatic wait_req(output bit got);
        int n;
        n = 0;
        while (!(bus.sdram_wr_req || bus.sdram_rd_req) && n < 64) begin
            tick();
            n++;
        end
        got = bus.sdram_wr_req || bus.sdram_rd_req;
    endtask

    task automatic set_ack(input bit is_wr, input logic v);
        if (is_wr) bus.sdram_wr_ack = v;
        else       bus.sdram_rd_ack = v;
    endtask

    task automatic set_load(input bit is_wr, input logic v);
        if (is_wr) wr_load = v;
        else       rd_load = v;
    endtask

    // Acts as the SDRAM controller for one burst of the expected direction.
    task automatic serve(input bit is_wr, input int dly, input int dur,
                         input logic [ADDR_W-1:0] a0, input bit ld,
                         input bit pulse, input logic [ADDR_W-1:0] a1);
        bit got;
        wait_req(got);
        check("req_seen", 32'(got), 1);
        check("grant_dir", {bus.sdram_wr_req, bus.sdram_rd_req},
              is_wr ? 2'b10 : 2'b01);
        check("req_addr", addr_of(is_wr), a0);
        repeat (dly) tick();
        check("req_held", req_of(is_wr), 1);
        set_ack(is_wr, 1'b1);
        tick();
        check("req_drop", req_of(is_wr), 0);
        for (int i = 1; i < dur; i++) begin
            if (ld && i == 1) set_load(is_wr, 1'b1);
            tick();
            set_load(is_wr, 1'b0);
        end
        set_ack(is_wr, 1'b0);
        tick();
        check("done_pulse", pulse_of(is_wr), pulse);
        check("addr_stable", addr_of(is_wr), a0);
        tick();
        check("next_addr", addr_of(is_wr), a1);
        check("pulse_1cyc", pulse_of(is_wr), 0);
    endtask

    initial begin
        bit got;
        int n;
        logic [ADDR_W-1:0] wp, rp, wb, wm, rb, rm, e1;
        bit last_wr, wrap, dir, ld;
        int mode, wl, rl;

        checks = 0;
        failures = 0;
        rst = 1'b1;
        sdram_init_done = 1'b0;
        wrf_usedw = '0;
        rdf_usedw = '0;
        data_valid = 1'b0;
        wr_length = '0;
        rd_length = '0;
        wr_addr = '0;
        wr_max_addr = '0;
        wr_load = 1'b0;
        rd_addr = '0;
        rd_max_addr = '0;
        rd_load = 1'b0;
        bus.sdram_wr_ack = 1'b0;
        bus.sdram_rd_ack = 1'b0;
        repeat (3) tick();

        check("rst_wr_req", bus.sdram_wr_req, 0);
        check("rst_rd_req", bus.sdram_rd_req, 0);
        check("rst_wraddr", bus.sdram_wraddr, 0);
        check("rst_rdaddr", bus.sdram_rdaddr, 0);
        check("rst_fwd", frame_write_done, 0);
        check("rst_frd", frame_read_done, 0);
        check("rst_err", ack_timeout_err, 0);

        // Init gating
        rst = 1'b0;
        wrf_usedw = 10'd300;
        wr_length = 9'd256;
        wr_max_addr = 22'd768;
        rd_length = 9'd256;
        repeat (5) tick();
        check("gated_no_req", bus.sdram_wr_req, 0);
        sdram_init_done = 1'b1;
        tick();
        check("init_req", bus.sdram_wr_req, 1);
        check("init_addr", bus.sdram_wraddr, 0);

        // Handshake, then wrap on the third burst
        serve(1'b1, 2, 256, 22'd0, 1'b0, 1'b0, 22'd256);
        serve(1'b1, 1, 8, 22'd256, 1'b0, 1'b0, 22'd512);
        serve(1'b1, 1, 8, 22'd512, 1'b0, 1'b1, 22'd0);

        // Deferred load during the burst at 512 suppresses the frame pulse
        serve(1'b1, 0, 4, 22'd0, 1'b0, 1'b0, 22'd256);
        serve(1'b1, 0, 4, 22'd256, 1'b0, 1'b0, 22'd512);
        serve(1'b1, 0, 4, 22'd512, 1'b1, 1'b0, 22'd0);

        // Timeout: never ack
        wait_req(got);
        check("to_req_seen", 32'(got), 1);
        wrf_usedw = '0;
        n = 0;
        while (bus.sdram_wr_req && n < 5000) begin
            tick();
            n++;
        end
        check("to_req_cycles", n, ACK_TO);
        check("to_err_set", ack_timeout_err, 1);
        check("to_addr_kept", bus.sdram_wraddr, 0);
        repeat (3) tick();
        check("to_err_sticky", ack_timeout_err, 1);
        check("to_no_retry", bus.sdram_wr_req, 0);

        // Round-robin from a fresh reset; first grant is write
        rst = 1'b1;
        repeat (2) tick();
        check("rst_err_clr", ack_timeout_err, 0);
        wrf_usedw = 10'd300;
        data_valid = 1'b1;
        rdf_usedw = '0;
        rd_addr = 22'h1000;
        rd_max_addr = 22'h1300;
        rst = 1'b0;
        rd_load = 1'b1;
        tick();
        rd_load = 1'b0;
        serve(1'b1, 0, 4, 22'd0, 1'b0, 1'b0, 22'd256);
        serve(1'b0, 0, 4, 22'h1000, 1'b0, 1'b0, 22'h1100);
        serve(1'b1, 0, 4, 22'd256, 1'b0, 1'b0, 22'd512);
        serve(1'b0, 0, 4, 22'h1100, 1'b0, 1'b0, 22'h1200);

        // Read-FIFO space boundary
        wrf_usedw = '0;
        rdf_usedw = 10'd769;
        repeat (6) tick();
        check("rdf_full_no_req", bus.sdram_rd_req, 0);
        check("rdf_full_no_wr", bus.sdram_wr_req, 0);
        rdf_usedw = 10'd768;
        serve(1'b0, 1, 4, 22'h1200, 1'b0, 1'b1, 22'h1000);

        // Random bursts against the frame-pointer model
        rst = 1'b1;
        data_valid = 1'b0;
        wrf_usedw = '0;
        repeat (2) tick();
        rst = 1'b0;
        wb = ADDR_W'($urandom_range(0, 4096));
        wm = wb + ADDR_W'($urandom_range(300, 3000));
        rb = ADDR_W'($urandom_range(8192, 12288));
        rm = rb + ADDR_W'($urandom_range(300, 3000));
        wr_addr = wb;
        wr_max_addr = wm;
        rd_addr = rb;
        rd_max_addr = rm;
        wr_load = 1'b1;
        rd_load = 1'b1;
        tick();
        wr_load = 1'b0;
        rd_load = 1'b0;
        tick();
        check("rnd_wload", bus.sdram_wraddr, wb);
        check("rnd_rload", bus.sdram_rdaddr, rb);
        wp = wb;
        rp = rb;
        last_wr = 1'b0;
        for (int k = 0; k < 40; k++) begin
            wl = $urandom_range(1, 256);
            rl = $urandom_range(1, 256);
            mode = $urandom_range(0, 2);
            wr_length = 9'(wl);
            rd_length = 9'(rl);
            wrf_usedw = (mode == 1) ? 10'd0
                      : 10'(wl + $urandom_range(0, 1023 - wl));
            data_valid = (mode != 0);
            rdf_usedw = 10'($urandom_range(0, 1024 - rl));
            dir = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : !last_wr;
            ld = ($urandom_range(0, 3) == 0);
            if (dir) e1 = advance(wp, wl, wb, wm, wrap);
            else     e1 = advance(rp, rl, rb, rm, wrap);
            if (ld) begin
                e1 = dir ? wb : rb;
                wrap = 1'b0;
            end
            serve(dir, $urandom_range(0, 3), $urandom_range(2, 6),
                  dir ? wp : rp, ld, wrap, e1);
            if (dir) wp = e1;
            else     rp = e1;
            last_wr = dir;
        end
        check("rnd_no_err", ack_timeout_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
